// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer.
// Holds state encodings, opcode/funct codes, ALU operation codes,
// mux-select encodings and the instruction class produced by the decoder.
package mcpu_defs;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } stateT;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // Funct codes (IR[5:0]) for R-type
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Register-file destination select
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // Next-PC select
    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_RS     = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    // Write-back data and ALU operand selects
    localparam logic REG_FROM_ALU   = 1'b0;
    localparam logic REG_FROM_MEM   = 1'b1;
    localparam logic ALU_FROM_RS    = 1'b0;
    localparam logic ALU_FROM_SHAMT = 1'b1;
    localparam logic ALU_FROM_RT    = 1'b0;
    localparam logic ALU_FROM_IMM   = 1'b1;

    // Instruction class, drives the ID-state branching of the sequencer
    typedef enum logic [3:0] {
        CLS_NOP  = 4'd0,
        CLS_J    = 4'd1,
        CLS_JAL  = 4'd2,
        CLS_JR   = 4'd3,
        CLS_HALT = 4'd4,
        CLS_BR   = 4'd5,
        CLS_LS   = 4'd6,
        CLS_ALR  = 4'd7,
        CLS_ALI  = 4'd8
    } instClassT;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multi-cycle sequencer and the datapath.
// master: sequencer side (takes instruction fields/ALU flags, drives controls).
// slave : datapath side (drives instruction fields/ALU flags, takes controls).
interface multicycle_control_fsm_if
    import mcpu_defs::*;
#(
    parameter int CNT_W = 32
);
    logic [5:0]       Opcode;
    logic [5:0]       Funct;
    logic             Zero;
    logic             Sign;
    logic             PCWrite;
    logic             IRWrite;
    logic             RegWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             ALUSrcA;
    logic             ALUSrcB;
    logic             MemToReg;
    logic             WrDataPC;
    logic [1:0]       RegDst;
    logic             ExtSel;
    logic [1:0]       PCSrc;
    logic [2:0]       ALUOp;
    stateT            State;
    logic             Halted;
    logic [CNT_W-1:0] InstRet;

    modport master (
        input  Opcode, Funct, Zero, Sign,
        output PCWrite, IRWrite, RegWrite, MemRead, MemWrite, ALUSrcA, ALUSrcB,
               MemToReg, WrDataPC, RegDst, ExtSel, PCSrc, ALUOp, State, Halted,
               InstRet
    );

    modport slave (
        output Opcode, Funct, Zero, Sign,
        input  PCWrite, IRWrite, RegWrite, MemRead, MemWrite, ALUSrcA, ALUSrcB,
               MemToReg, WrDataPC, RegDst, ExtSel, PCSrc, ALUOp, State, Halted,
               InstRet
    );
endinterface

// File: rtl/mcpu_op_decode.sv
// Combinational instruction decoder.
// Ports: opcode/funct in; aluOp, extSel and instruction class out.
// The halt opcode takes priority over every other decoding.
module mcpu_op_decode
    import mcpu_defs::*;
#(
    parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] aluOp,
    output logic       extSel,
    output instClassT  instClass
);
    always_comb begin
        aluOp     = ALU_ADD;
        extSel    = 1'b0;
        instClass = CLS_NOP;
        if (opcode == HALT_OPCODE) begin
            instClass = CLS_HALT;
        end else begin
            case (opcode)
                OP_R: begin
                    instClass = CLS_ALR;
                    case (funct)
                        FN_ADD:  aluOp = ALU_ADD;
                        FN_SUB:  aluOp = ALU_SUB;
                        FN_AND:  aluOp = ALU_AND;
                        FN_OR:   aluOp = ALU_OR;
                        FN_SLT:  aluOp = ALU_SLT;
                        FN_SLL:  aluOp = ALU_SLL;
                        FN_JR:   instClass = CLS_JR;
                        default: instClass = CLS_NOP;
                    endcase
                end
                OP_ADDIU: begin instClass = CLS_ALI; aluOp = ALU_ADD; extSel = 1'b1; end
                OP_SLTI:  begin instClass = CLS_ALI; aluOp = ALU_SLT; extSel = 1'b1; end
                OP_ANDI:  begin instClass = CLS_ALI; aluOp = ALU_AND; end
                OP_ORI:   begin instClass = CLS_ALI; aluOp = ALU_OR;  end
                OP_LW, OP_SW: begin
                    instClass = CLS_LS; aluOp = ALU_ADD; extSel = 1'b1;
                end
                OP_BEQ, OP_BNE, OP_BLTZ: begin
                    instClass = CLS_BR; aluOp = ALU_SUB; extSel = 1'b1;
                end
                OP_J:    instClass = CLS_J;
                OP_JAL:  instClass = CLS_JAL;
                default: instClass = CLS_NOP;
            endcase
        end
    end
endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer (IF, ID, EXE, MEM, WB).
// Ports: CLK, Reset (sync, active-low), bus (master modport) carrying
// Opcode/Funct/Zero/Sign in and all datapath enables/selects, debug State,
// sticky Halted flag and retired-instruction counter InstRet out.
module multicycle_control_fsm
    import mcpu_defs::*;
#(
    parameter int         CNT_W       = 32,
    parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
    input  logic                     CLK,
    input  logic                     Reset,
    multicycle_control_fsm_if.master bus
);
    stateT            state, nextState;
    logic             halted;
    logic [CNT_W-1:0] instRet;

    logic [2:0] decAluOp;
    logic       decExtSel;
    instClassT  instClass;

    logic       pcWrite, irWrite, regWrite, memRead, memWrite;
    logic       aluSrcA, aluSrcB, memToReg, wrDataPC, extSel, haltNow;
    logic [1:0] regDst, pcSrc;
    logic [2:0] aluOp;

    mcpu_op_decode #(.HALT_OPCODE(HALT_OPCODE)) uDecode (
        .opcode    (bus.Opcode),
        .funct     (bus.Funct),
        .aluOp     (decAluOp),
        .extSel    (decExtSel),
        .instClass (instClass)
    );

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state   <= S_IF;
            halted  <= 1'b0;
            instRet <= '0;
        end else begin
            state <= nextState;
            if (haltNow) halted <= 1'b1;
            if (pcWrite) instRet <= instRet + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        nextState = state;
        pcWrite   = 1'b0;
        irWrite   = 1'b0;
        regWrite  = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        aluSrcA   = ALU_FROM_RS;
        aluSrcB   = ALU_FROM_RT;
        memToReg  = REG_FROM_ALU;
        wrDataPC  = 1'b0;
        regDst    = REGDST_RT;
        pcSrc     = PCSRC_PLUS4;
        haltNow   = 1'b0;
        // Decoded ALU op and extension stay valid from ID to the end of the instruction
        extSel    = (state != S_IF) ? decExtSel : 1'b0;
        aluOp     = (state != S_IF) ? decAluOp  : ALU_ADD;

        case (state)
            S_IF: begin
                irWrite   = 1'b1;
                nextState = S_ID;
            end
            S_ID: begin
                // A halted core parks in ID whatever the instruction fields show
                if (halted || instClass == CLS_HALT) begin
                    haltNow   = 1'b1;
                    nextState = S_ID;
                end else begin
                    case (instClass)
                        CLS_J: begin
                            pcSrc = PCSRC_JUMP; pcWrite = 1'b1; nextState = S_IF;
                        end
                        CLS_JAL: begin
                            pcSrc = PCSRC_JUMP; pcWrite = 1'b1; nextState = S_IF;
                            regWrite = 1'b1; regDst = REGDST_RA; wrDataPC = 1'b1;
                        end
                        CLS_JR: begin
                            pcSrc = PCSRC_RS; pcWrite = 1'b1; nextState = S_IF;
                        end
                        CLS_BR:           nextState = S_EXE_BR;
                        CLS_LS:           nextState = S_EXE_LS;
                        CLS_ALR, CLS_ALI: nextState = S_EXE_AL;
                        default: begin
                            pcSrc = PCSRC_PLUS4; pcWrite = 1'b1; nextState = S_IF;
                        end
                    endcase
                end
            end
            S_EXE_AL: begin
                aluSrcB   = (instClass == CLS_ALI) ? ALU_FROM_IMM : ALU_FROM_RT;
                aluSrcA   = (instClass == CLS_ALR && bus.Funct == FN_SLL) ? ALU_FROM_SHAMT
                                                                          : ALU_FROM_RS;
                nextState = S_WB_AL;
            end
            S_WB_AL: begin
                regWrite  = 1'b1;
                memToReg  = REG_FROM_ALU;
                regDst    = (instClass == CLS_ALR) ? REGDST_RD : REGDST_RT;
                pcWrite   = 1'b1;
                pcSrc     = PCSRC_PLUS4;
                nextState = S_IF;
            end
            S_EXE_BR: begin
                aluOp   = ALU_SUB;
                extSel  = 1'b1;
                pcWrite = 1'b1;
                if ((bus.Opcode == OP_BEQ  &&  bus.Zero) ||
                    (bus.Opcode == OP_BNE  && !bus.Zero) ||
                    (bus.Opcode == OP_BLTZ &&  bus.Sign))
                    pcSrc = PCSRC_BRANCH;
                nextState = S_IF;
            end
            S_EXE_LS: begin
                aluSrcB   = ALU_FROM_IMM;
                aluOp     = ALU_ADD;
                extSel    = 1'b1;
                nextState = S_MEM;
            end
            S_MEM: begin
                if (bus.Opcode == OP_LW) begin
                    memRead   = 1'b1;
                    nextState = S_WB_LD;
                end else begin
                    memWrite  = 1'b1;
                    pcWrite   = 1'b1;
                    nextState = S_IF;
                end
            end
            S_WB_LD: begin
                regWrite  = 1'b1;
                memToReg  = REG_FROM_MEM;
                regDst    = REGDST_RT;
                pcWrite   = 1'b1;
                nextState = S_IF;
            end
            default: nextState = S_IF;
        endcase
    end

    // Reset forces every output low, so an aborted instruction cannot write anything
    assign bus.PCWrite  = Reset & pcWrite;
    assign bus.IRWrite  = Reset & irWrite;
    assign bus.RegWrite = Reset & regWrite;
    assign bus.MemRead  = Reset & memRead;
    assign bus.MemWrite = Reset & memWrite;
    assign bus.ALUSrcA  = Reset & aluSrcA;
    assign bus.ALUSrcB  = Reset & aluSrcB;
    assign bus.MemToReg = Reset & memToReg;
    assign bus.WrDataPC = Reset & wrDataPC;
    assign bus.ExtSel   = Reset & extSel;
    assign bus.RegDst   = {2{Reset}} & regDst;
    assign bus.PCSrc    = {2{Reset}} & pcSrc;
    assign bus.ALUOp    = {3{Reset}} & aluOp;
    assign bus.State    = Reset ? state : S_IF;
    assign bus.Halted   = Reset & halted;
    assign bus.InstRet  = {CNT_W{Reset}} & instRet;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multi-cycle control sequencer.
module tb_multicycle_control_fsm;
    import mcpu_defs::*;

    logic CLK;
    logic Reset;
    int   nCompared;
    int   nMismatched;

    multicycle_control_fsm_if #(.CNT_W(32)) bus ();

    multicycle_control_fsm #(.CNT_W(32), .HALT_OPCODE(6'b111111)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic setInstr(input logic [5:0] op, input logic [5:0] fn);
        bus.Opcode = op;
        bus.Funct  = fn;
        #1;
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        Reset    = 1'b0;
        bus.Zero = 1'b0;
        bus.Sign = 1'b0;
        setInstr(OP_R, FN_ADD);

        // Reset held for two edges: everything forced low
        tick();
        tick();
        checkVal("rstState",   32'(bus.State),   32'(S_IF));
        checkVal("rstIRWrite", 32'(bus.IRWrite), 0);
        checkVal("rstHalted",  32'(bus.Halted),  0);
        checkVal("rstInstRet", 32'(bus.InstRet), 0);

        // add: IF, ID, EXE_AL, WB_AL, IF
        Reset = 1'b1;
        #1;
        checkVal("addIF",      32'(bus.State),    32'(S_IF));
        checkVal("addIRWrite", 32'(bus.IRWrite),  1);
        tick();
        checkVal("addID",      32'(bus.State),    32'(S_ID));
        checkVal("addIDPCW",   32'(bus.PCWrite),  0);
        checkVal("addIDRegW",  32'(bus.RegWrite), 0);
        tick();
        checkVal("addEXE",     32'(bus.State),    32'(S_EXE_AL));
        checkVal("addEXESrcB", 32'(bus.ALUSrcB),  0);
        checkVal("addEXERegW", 32'(bus.RegWrite), 0);
        tick();
        checkVal("addWB",      32'(bus.State),    32'(S_WB_AL));
        checkVal("addWBRegW",  32'(bus.RegWrite), 1);
        checkVal("addWBDst",   32'(bus.RegDst),   1);
        checkVal("addWBPCW",   32'(bus.PCWrite),  1);
        tick();
        checkVal("addBackIF",  32'(bus.State),    32'(S_IF));
        checkVal("addInstRet", 32'(bus.InstRet),  1);

        // sll: ALUSrcA selects shamt in EXE
        setInstr(OP_R, FN_SLL);
        tick(); tick();
        checkVal("sllSrcA",    32'(bus.ALUSrcA),  1);
        checkVal("sllALUOp",   32'(bus.ALUOp),    32'(ALU_SLL));
        tick(); tick();
        checkVal("sllInstRet", 32'(bus.InstRet),  2);

        // lw: 5 cycles
        setInstr(OP_LW, 6'd0);
        tick();
        tick();
        checkVal("lwEXE",      32'(bus.State),    32'(S_EXE_LS));
        checkVal("lwEXESrcB",  32'(bus.ALUSrcB),  1);
        checkVal("lwEXEExt",   32'(bus.ExtSel),   1);
        checkVal("lwEXERead",  32'(bus.MemRead),  0);
        tick();
        checkVal("lwMEM",      32'(bus.State),    32'(S_MEM));
        checkVal("lwMEMRead",  32'(bus.MemRead),  1);
        checkVal("lwMEMPCW",   32'(bus.PCWrite),  0);
        tick();
        checkVal("lwWB",       32'(bus.State),    32'(S_WB_LD));
        checkVal("lwWBRegW",   32'(bus.RegWrite), 1);
        checkVal("lwWBM2R",    32'(bus.MemToReg), 1);
        checkVal("lwWBPCW",    32'(bus.PCWrite),  1);
        checkVal("lwWBRead",   32'(bus.MemRead),  0);
        tick();
        checkVal("lwBackIF",   32'(bus.State),    32'(S_IF));
        checkVal("lwInstRet",  32'(bus.InstRet),  3);

        // beq taken
        setInstr(OP_BEQ, 6'd0);
        bus.Zero = 1'b1;
        tick(); tick();
        checkVal("beqTState",  32'(bus.State),    32'(S_EXE_BR));
        checkVal("beqTPCSrc",  32'(bus.PCSrc),    1);
        checkVal("beqTPCW",    32'(bus.PCWrite),  1);
        checkVal("beqTALUOp",  32'(bus.ALUOp),    32'(ALU_SUB));
        tick();
        checkVal("beqTIF",     32'(bus.State),    32'(S_IF));

        // beq not taken
        bus.Zero = 1'b0;
        tick(); tick();
        checkVal("beqNPCSrc",  32'(bus.PCSrc),    0);
        checkVal("beqNPCW",    32'(bus.PCWrite),  1);
        tick();

        // bltz taken on Sign
        setInstr(OP_BLTZ, 6'd0);
        bus.Sign = 1'b1;
        tick(); tick();
        checkVal("bltzPCSrc",  32'(bus.PCSrc),    1);
        tick();
        bus.Sign = 1'b0;
        checkVal("brInstRet",  32'(bus.InstRet),  6);

        // jal: 2 cycles
        setInstr(OP_JAL, 6'd0);
        tick();
        checkVal("jalPCSrc",   32'(bus.PCSrc),    3);
        checkVal("jalRegW",    32'(bus.RegWrite), 1);
        checkVal("jalDst",     32'(bus.RegDst),   2);
        checkVal("jalWrPC",    32'(bus.WrDataPC), 1);
        checkVal("jalPCW",     32'(bus.PCWrite),  1);
        tick();
        checkVal("jalIF",      32'(bus.State),    32'(S_IF));
        checkVal("jalInstRet", 32'(bus.InstRet),  7);

        // jr
        setInstr(OP_R, FN_JR);
        tick();
        checkVal("jrPCSrc",    32'(bus.PCSrc),    2);
        checkVal("jrPCW",      32'(bus.PCWrite),  1);
        tick();

        // Undefined opcode behaves as NOP
        setInstr(6'b111110, 6'd0);
        tick();
        checkVal("nopPCSrc",   32'(bus.PCSrc),    0);
        checkVal("nopPCW",     32'(bus.PCWrite),  1);
        tick();
        checkVal("nopIF",      32'(bus.State),    32'(S_IF));
        checkVal("nopInstRet", 32'(bus.InstRet),  9);

        // Halt: parks in ID, no PC writes, counter frozen
        setInstr(6'b111111, 6'd0);
        tick();
        checkVal("haltID",     32'(bus.State),    32'(S_ID));
        checkVal("haltPCW0",   32'(bus.PCWrite),  0);
        checkVal("haltFlag0",  32'(bus.Halted),   0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkVal("haltPCW",   32'(bus.PCWrite), 0);
            checkVal("haltState", 32'(bus.State),   32'(S_ID));
            checkVal("haltFlag",  32'(bus.Halted),  1);
        end
        checkVal("haltInstRet", 32'(bus.InstRet), 9);

        // Reset clears the halt
        Reset = 1'b0;
        #1;
        checkVal("haltRstFlag", 32'(bus.Halted), 0);
        tick();
        Reset = 1'b1;
        setInstr(OP_SW, 6'd0);
        checkVal("postRstFlag",  32'(bus.Halted),  0);
        checkVal("postRstState", 32'(bus.State),   32'(S_IF));
        checkVal("postRstCnt",   32'(bus.InstRet), 0);

        // sw aborted by reset during MEM
        tick(); tick(); tick();
        checkVal("swMEM",      32'(bus.State),    32'(S_MEM));
        checkVal("swMemW",     32'(bus.MemWrite), 1);
        checkVal("swPCW",      32'(bus.PCWrite),  1);
        Reset = 1'b0;
        #1;
        checkVal("swAbortMW",  32'(bus.MemWrite), 0);
        checkVal("swAbortPCW", 32'(bus.PCWrite),  0);
        tick();
        Reset = 1'b1;
        #1;
        checkVal("swAbortIF",  32'(bus.State),    32'(S_IF));
        checkVal("swAbortCnt", 32'(bus.InstRet),  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
